// File: rtl/t_fetch_align_pkg.sv
// Shared types for the fetch aligner: FSM state encoding and the predictor-facing bundle.
package tcore_param;

  typedef enum logic [2:0] {EMPTY, FULL_LO, FULL_HI, SPLIT, SPLIT_RDY} align_state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic        is_comp;
    logic [31:0] pc;
    logic [31:0] pc2;
    logic [31:0] pc4;
    logic        valid;
  } fetch_out_t;

  function automatic logic is_comp16(input logic [1:0] lo);
    return lo != 2'b11;
  endfunction

endpackage

// File: rtl/t_fetch_align.sv
// RV32IMC fetch aligner: turns aligned 32-bit cache words into one instruction per cycle,
// stitching 32-bit instructions that straddle a word boundary through a carried halfword.
module t_fetch_align
  import tcore_param::*;
#(
  parameter logic [31:0] RESET_VECTOR = 32'h4000_0000
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        flush_i,
  input  logic [31:0] flush_pc_i,
  output logic        fetch_req_o,
  output logic [31:0] fetch_addr_o,
  input  logic        fetch_ack_i,
  input  logic [31:0] fetch_data_i,
  input  logic        stall_i,
  output logic        valid_o,
  output logic [31:0] inst_o,
  output logic        is_comp_o,
  output logic [31:0] pc_o,
  output logic [31:0] pc2_o,
  output logic [31:0] pc4_o
);

  align_state_t r_state, w_state;
  logic [31:0]  r_w, w_w, r_a, w_a, r_ca, w_ca, r_f, w_f;
  logic [15:0]  r_c, w_c;
  logic         r_skip_lo, w_skip_lo;
  fetch_out_t   r_out, w_out;

  logic        w_consume, w_lo_comp, w_hi_comp, w_drain, w_req, w_ack;
  logic [31:0] w_a4;

  assign w_consume = r_out.valid & ~stall_i;
  assign w_lo_comp = is_comp16(r_w[1:0]);
  assign w_hi_comp = is_comp16(r_w[17:16]);
  assign w_a4      = r_a + 32'd4;

  // Consuming the last instruction in W lets the next word be requested in the same cycle.
  assign w_drain = w_consume & (((r_state == FULL_LO) & ~w_lo_comp) |
                                ((r_state == FULL_HI) &  w_hi_comp));
  assign w_req   = ~rst_i & ~flush_i & ((r_state == EMPTY) | (r_state == SPLIT) | w_drain);
  assign w_ack   = fetch_ack_i & w_req;

  assign fetch_req_o  = w_req;
  assign fetch_addr_o = ((r_state == EMPTY) | (r_state == SPLIT)) ? r_f : w_a4;

  always_comb begin
    w_state   = r_state;
    w_w       = r_w;
    w_a       = r_a;
    w_c       = r_c;
    w_ca      = r_ca;
    w_f       = r_f;
    w_skip_lo = r_skip_lo;
    if (flush_i) begin
      w_state   = EMPTY;
      w_w       = '0;
      w_c       = '0;
      w_f       = {flush_pc_i[31:2], 2'b00};
      w_skip_lo = flush_pc_i[1];
    end else begin
      case (r_state)
        EMPTY: if (w_ack) begin
          w_w       = fetch_data_i;
          w_a       = r_f;
          w_state   = r_skip_lo ? FULL_HI : FULL_LO;
          w_skip_lo = 1'b0;
        end
        FULL_LO: if (w_consume) begin
          if (w_lo_comp) begin
            w_state = FULL_HI;
          end else begin
            w_f     = w_a4;
            w_state = w_ack ? FULL_LO : EMPTY;
            if (w_ack) begin
              w_w = fetch_data_i;
              w_a = w_a4;
            end
          end
        end
        FULL_HI: begin
          if (w_hi_comp) begin
            if (w_consume) begin
              w_f     = w_a4;
              w_state = w_ack ? FULL_LO : EMPTY;
              if (w_ack) begin
                w_w = fetch_data_i;
                w_a = w_a4;
              end
            end
          end else begin
            w_c     = r_w[31:16];
            w_ca    = r_a + 32'd2;
            w_f     = w_a4;
            w_state = SPLIT;
          end
        end
        SPLIT: if (w_ack) begin
          w_w     = fetch_data_i;
          w_a     = r_f;
          w_state = SPLIT_RDY;
        end
        SPLIT_RDY: if (w_consume) w_state = FULL_HI;
        default: w_state = EMPTY;
      endcase
    end
  end

  // Outputs are decoded from the next state so they can be registered without adding latency.
  always_comb begin
    w_out       = r_out;
    w_out.valid = 1'b0;
    case (w_state)
      FULL_LO: begin
        w_out.valid = 1'b1;
        w_out.pc    = w_a;
        w_out.inst  = is_comp16(w_w[1:0]) ? {16'h0, w_w[15:0]} : w_w;
      end
      FULL_HI: if (is_comp16(w_w[17:16])) begin
        w_out.valid = 1'b1;
        w_out.pc    = w_a + 32'd2;
        w_out.inst  = {16'h0, w_w[31:16]};
      end
      SPLIT_RDY: begin
        w_out.valid = 1'b1;
        w_out.pc    = w_ca;
        w_out.inst  = {w_w[15:0], w_c};
      end
      default: ;
    endcase
    if (w_out.valid) begin
      w_out.is_comp = is_comp16(w_out.inst[1:0]);
      w_out.pc2     = w_out.pc + 32'd2;
      w_out.pc4     = w_out.pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state   <= EMPTY;
      r_w       <= '0;
      r_a       <= RESET_VECTOR;
      r_c       <= '0;
      r_ca      <= '0;
      r_f       <= RESET_VECTOR;
      r_skip_lo <= 1'b0;
      r_out     <= '{inst: 32'h0, is_comp: 1'b0, pc: RESET_VECTOR,
                     pc2: RESET_VECTOR + 32'd2, pc4: RESET_VECTOR + 32'd4, valid: 1'b0};
    end else begin
      r_state   <= w_state;
      r_w       <= w_w;
      r_a       <= w_a;
      r_c       <= w_c;
      r_ca      <= w_ca;
      r_f       <= w_f;
      r_skip_lo <= w_skip_lo;
      r_out     <= w_out;
    end
  end

  assign valid_o   = r_out.valid;
  assign inst_o    = r_out.inst;
  assign is_comp_o = r_out.is_comp;
  assign pc_o      = r_out.pc;
  assign pc2_o     = r_out.pc2;
  assign pc4_o     = r_out.pc4;

endmodule
